// File: rtl/dtm_pkg.sv
// Shared definitions for the gate-drive dead-time monitor: FSM state encoding
// and the default dead-time minimum, which the dead-time generator also uses.
package dtm_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_HS_ON = 2'd1,
    ST_LS_ON = 2'd2,
    ST_FAULT = 2'd3
  } dtm_state_e;

  localparam int unsigned DTM_MIN_DT = 11;

endpackage

// File: rtl/dtm_sync2.sv
// 1-bit two-flop synchronizer with asynchronous active-high reset.
module dtm_sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta <= 1'b0;
      Q    <= 1'b0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/dead_time_monitor.sv
// Dead-time monitor for one inverter leg: measures HS/LS off-gaps and latches
// shoot-through. Define DTM_SYNC_EN to put two-flop synchronizers on HS/LS.
module dead_time_monitor
  import dtm_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned MIN_DT = DTM_MIN_DT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             HS,
  input  logic             LS,
  input  logic             CLR,
  output logic [CNT_W-1:0] DT_MEAS,
  output logic             DT_VALID,
  output logic             DT_ERR,
  output logic             SHOOT,
  output logic [7:0]       FAULT_CNT
);

  logic hs_q, ls_q;

`ifdef DTM_SYNC_EN
  dtm_sync2 u_sync_hs (.CLK(CLK), .RST(RST), .D(HS), .Q(hs_q));
  dtm_sync2 u_sync_ls (.CLK(CLK), .RST(RST), .D(LS), .Q(ls_q));
`else
  assign hs_q = HS;
  assign ls_q = LS;
`endif

  logic h, l;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h <= 1'b0;
      l <= 1'b0;
    end else begin
      h <= hs_q;
      l <= ls_q;
    end
  end

  dtm_state_e       state, state_nx;
  logic [CNT_W-1:0] gap, gap_nx;
  logic             armed, armed_nx;
  logic             on_entry, fault_entry, meas;
  logic [CNT_W-1:0] dt_meas_nx;
  logic             dt_valid_nx, dt_err_nx, shoot_nx;
  logic [7:0]       fault_cnt_nx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_OFF;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = ST_OFF;
    gap_nx       = '0;
    armed_nx     = armed;
    dt_meas_nx   = DT_MEAS;
    dt_valid_nx  = 1'b0;
    dt_err_nx    = 1'b0;
    shoot_nx     = SHOOT;
    fault_cnt_nx = FAULT_CNT;

    unique case ({h, l})
      2'b11:   state_nx = ST_FAULT;
      2'b10:   state_nx = ST_HS_ON;
      2'b01:   state_nx = ST_LS_ON;
      default: state_nx = ST_OFF;
    endcase

    // The gap is the number of both-low samples seen since the last on-sample
    if ({h, l} == 2'b00) gap_nx = (gap == '1) ? gap : gap + CNT_W'(1);

    on_entry    = (state_nx == ST_HS_ON || state_nx == ST_LS_ON) && (state_nx != state);
    fault_entry = (state_nx == ST_FAULT) && (state != ST_FAULT);
    meas        = on_entry && armed && (state != ST_FAULT);

    if (meas) begin
      dt_meas_nx  = gap;
      dt_valid_nx = 1'b1;
      dt_err_nx   = (32'(gap) < MIN_DT);
    end

    if (CLR) armed_nx = 1'b0;
    if (on_entry) armed_nx = 1'b1;

    // A fault entry in the same cycle as CLR restarts the count at one
    if (fault_entry) begin
      shoot_nx     = 1'b1;
      fault_cnt_nx = CLR ? 8'd1 : ((FAULT_CNT == 8'hFF) ? FAULT_CNT : FAULT_CNT + 8'd1);
    end else if (CLR) begin
      shoot_nx     = 1'b0;
      fault_cnt_nx = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gap       <= '0;
      armed     <= 1'b0;
      DT_MEAS   <= '0;
      DT_VALID  <= 1'b0;
      DT_ERR    <= 1'b0;
      SHOOT     <= 1'b0;
      FAULT_CNT <= '0;
    end else begin
      gap       <= gap_nx;
      armed     <= armed_nx;
      DT_MEAS   <= dt_meas_nx;
      DT_VALID  <= dt_valid_nx;
      DT_ERR    <= dt_err_nx;
      SHOOT     <= shoot_nx;
      FAULT_CNT <= fault_cnt_nx;
    end
  end

endmodule

// File: tb/tb_dead_time_monitor.sv
// Directed self-checking bench for dead_time_monitor (default and DTM_SYNC_EN builds).
module tb_dead_time_monitor;

`ifdef DTM_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       CLK = 1'b0;
  logic       RST, HS, LS, CLR;
  logic [7:0] DT_MEAS;
  logic       DT_VALID, DT_ERR, SHOOT;
  logic [7:0] FAULT_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  int         vcount = 0;
  int         stray  = 0;
  logic [7:0] last_meas = '0;
  logic       last_err  = 1'b0;

  dead_time_monitor #(.CNT_W(8), .MIN_DT(11)) dut (
    .CLK(CLK), .RST(RST), .HS(HS), .LS(LS), .CLR(CLR),
    .DT_MEAS(DT_MEAS), .DT_VALID(DT_VALID), .DT_ERR(DT_ERR),
    .SHOOT(SHOOT), .FAULT_CNT(FAULT_CNT)
  );

  always #5 CLK = ~CLK;

  // Records every measurement pulse shortly after the edge that produces it
  always @(posedge CLK) begin
    #2;
    if (DT_VALID) begin
      vcount++;
      last_meas = DT_MEAS;
      last_err  = DT_ERR;
    end
    if (DT_ERR && !DT_VALID) stray++;
  end

  task automatic drive(input logic h, input logic l, input int n);
    HS = h;
    LS = l;
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    HS  = 1'b0;
    LS  = 1'b0;
    CLR = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; HS = 1'b0; LS = 1'b0; CLR = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({DT_MEAS, DT_VALID, DT_ERR, SHOOT, FAULT_CNT} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got meas=%0d v=%b e=%b sh=%b fc=%0d want all 0",
               DT_MEAS, DT_VALID, DT_ERR, SHOOT, FAULT_CNT);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    int v0;
    v0 = vcount;
    drive(1, 0, 20);
    n_cmp++;
    if (vcount - v0 !== 0) begin
      n_bad++; $display("FAIL basic_first_unarmed: got %0d pulses want 0", vcount - v0);
    end
    drive(0, 0, 11);
    drive(0, 1, 6);
    n_cmp++;
    if (vcount - v0 !== 1) begin
      n_bad++; $display("FAIL basic_pulses: got %0d want 1", vcount - v0);
    end
    n_cmp++;
    if (last_meas !== 8'd11 || last_err !== 1'b0) begin
      n_bad++; $display("FAIL basic_meas: got %0d/err %b want 11/err 0", last_meas, last_err);
    end
  endtask

  task automatic test_not_armed();
    int v0;
    do_reset();
    v0 = vcount;
    drive(0, 0, 30);
    drive(1, 0, 10);
    n_cmp++;
    if (vcount - v0 !== 0) begin
      n_bad++; $display("FAIL unarmed_pulse: got %0d want 0", vcount - v0);
    end
    drive(0, 0, 4);
    drive(0, 1, 6);
    n_cmp++;
    if (vcount - v0 !== 1 || last_meas !== 8'd4 || last_err !== 1'b1) begin
      n_bad++; $display("FAIL armed_next: got n=%0d meas=%0d err=%b want n=1 meas=4 err=1",
                        vcount - v0, last_meas, last_err);
    end
  endtask

  task automatic test_short_gaps();
    int v0;
    v0 = vcount;
    drive(0, 0, 5);
    drive(1, 0, 6);
    n_cmp++;
    if (last_meas !== 8'd5 || last_err !== 1'b1) begin
      n_bad++; $display("FAIL short_gap: got %0d/err %b want 5/err 1", last_meas, last_err);
    end
    drive(0, 1, 6);
    n_cmp++;
    if (last_meas !== 8'd0 || last_err !== 1'b1) begin
      n_bad++; $display("FAIL direct_swap: got %0d/err %b want 0/err 1", last_meas, last_err);
    end
    drive(0, 0, 12);
    drive(0, 1, 6);
    n_cmp++;
    if (last_meas !== 8'd12 || last_err !== 1'b0) begin
      n_bad++; $display("FAIL same_side: got %0d/err %b want 12/err 0", last_meas, last_err);
    end
    n_cmp++;
    if (vcount - v0 !== 3 || stray !== 0) begin
      n_bad++; $display("FAIL short_pulses: got n=%0d stray=%0d want n=3 stray=0", vcount - v0, stray);
    end
  endtask

  task automatic test_fault();
    int v0;
    v0 = vcount;
    drive(1, 1, 3);
    drive(0, 1, 5);
    drive(1, 1, 3);
    drive(0, 0, 5);
    n_cmp++;
    if (SHOOT !== 1'b1 || FAULT_CNT !== 8'd2) begin
      n_bad++; $display("FAIL fault_two: got sh=%b fc=%0d want sh=1 fc=2", SHOOT, FAULT_CNT);
    end
    n_cmp++;
    if (vcount - v0 !== 0) begin
      n_bad++; $display("FAIL fault_no_meas: got %0d pulses want 0", vcount - v0);
    end
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    n_cmp++;
    if (SHOOT !== 1'b0 || FAULT_CNT !== 8'd0) begin
      n_bad++; $display("FAIL clr: got sh=%b fc=%0d want sh=0 fc=0", SHOOT, FAULT_CNT);
    end
    drive(1, 1, 3);
    drive(0, 0, 3);
    drive(1, 1, 3);
    drive(0, 0, 3);
    n_cmp++;
    if (FAULT_CNT !== 8'd2) begin
      n_bad++; $display("FAIL refault: got fc=%0d want 2", FAULT_CNT);
    end
    HS = 1'b1;
    LS = 1'b1;
    repeat (LAT - 1) @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    drive(1, 1, 2);
    drive(0, 0, 5);
    n_cmp++;
    if (SHOOT !== 1'b1 || FAULT_CNT !== 8'd1) begin
      n_bad++; $display("FAIL clr_vs_fault: got sh=%b fc=%0d want sh=1 fc=1", SHOOT, FAULT_CNT);
    end
    v0 = vcount;
    drive(1, 0, 6);
    n_cmp++;
    if (vcount - v0 !== 0) begin
      n_bad++; $display("FAIL clr_disarm: got %0d pulses want 0", vcount - v0);
    end
    drive(0, 0, 6);
    drive(0, 1, 6);
    n_cmp++;
    if (vcount - v0 !== 1 || last_meas !== 8'd6 || last_err !== 1'b1) begin
      n_bad++; $display("FAIL rearm: got n=%0d meas=%0d err=%b want n=1 meas=6 err=1",
                        vcount - v0, last_meas, last_err);
    end
  endtask

  task automatic test_saturate();
    drive(0, 0, 300);
    drive(1, 0, 6);
    n_cmp++;
    if (last_meas !== 8'd255 || last_err !== 1'b0) begin
      n_bad++; $display("FAIL saturate: got %0d/err %b want 255/err 0", last_meas, last_err);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    drive(0, 0, 6);
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({DT_MEAS, DT_VALID, DT_ERR, SHOOT, FAULT_CNT} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got meas=%0d v=%b e=%b sh=%b fc=%0d want all 0",
               DT_MEAS, DT_VALID, DT_ERR, SHOOT, FAULT_CNT);
    end
    @(negedge CLK);
    RST = 1'b0;
    v0 = vcount;
    drive(0, 0, 5);
    drive(0, 1, 6);
    n_cmp++;
    if (vcount - v0 !== 0) begin
      n_bad++; $display("FAIL reset_unarmed: got %0d pulses want 0", vcount - v0);
    end
    drive(0, 0, 7);
    drive(1, 0, 6);
    n_cmp++;
    if (vcount - v0 !== 1 || last_meas !== 8'd7) begin
      n_bad++; $display("FAIL reset_rearm: got n=%0d meas=%0d want n=1 meas=7", vcount - v0, last_meas);
    end
  endtask

  task automatic test_latency();
    logic [5:0] seen, want;
    seen = '0;
    want = '0;
    want[LAT-1] = 1'b1;
    drive(0, 0, 11);
    LS = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      seen[k] = DT_VALID;
    end
    n_cmp++;
    if (seen !== want) begin
      n_bad++; $display("FAIL latency: got valid pattern %b want %b", seen, want);
    end
    n_cmp++;
    if (DT_MEAS !== 8'd11) begin
      n_bad++; $display("FAIL latency_meas: got %0d want 11", DT_MEAS);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_not_armed();
    test_short_gaps();
    test_fault();
    test_saturate();
    test_reset_mid();
    test_latency();
    n_cmp++;
    if (stray !== 0) begin
      n_bad++; $display("FAIL err_without_valid: got %0d want 0", stray);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dead_time_monitor.md
# dead_time_monitor

- Checks the gate-drive pair that leaves the dead-time generator for one inverter leg.
- Watches the high-side and low-side gate signals. It measures every off-gap between them in CLK cycles and flags gaps shorter than the minimum.
- Detects shoot-through (both gates on at once) and latches it for the commutation/fault logic.
- One instance per phase leg. It sits between the dead-time stage outputs and the controller's fault aggregator.

## Interface
Parameters:
- CNT_W, 8, width of the gap counter and of DT_MEAS.
- MIN_DT, 11, minimum legal gap in cycles. A gap < MIN_DT is an error.

Ports:
- CLK  input  1  single clock. All logic is on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- HS  input  1  high-side gate drive, active-high.
- LS  input  1  low-side gate drive, active-high.
- CLR  input  1  synchronous clear of SHOOT, FAULT_CNT and the armed flag.
- DT_MEAS  output  CNT_W  last measured gap in cycles. Holds until the next measurement.
- DT_VALID  output  1  one-cycle pulse: DT_MEAS updated.
- DT_ERR  output  1  one-cycle pulse, coincident with DT_VALID, when DT_MEAS < MIN_DT.
- SHOOT  output  1  sticky shoot-through flag.
- FAULT_CNT  output  8  count of shoot-through events, saturating at 255.

## Operation
- HS and LS pass through a one-flop sample register, giving samples h and l. The FSM operates on h and l only.

FSM states: OFF, HS_ON, LS_ON, FAULT. Reset state is OFF.
- Any state with h=1, l=1 goes to FAULT.
- Otherwise h=1, l=0 goes to HS_ON.
- Otherwise h=0, l=1 goes to LS_ON.
- Otherwise h=0, l=0 goes to OFF.

Gap counter:
- Cleared to 0 on every sample that is not both-low.
- Increments by 1 on each both-low sample.
- Saturates at 2^CNT_W-1; it does not wrap.

Armed flag:
- Cleared by reset and by CLR.
- Set on any entry into HS_ON or LS_ON.

Measurement:
- Taken on every entry into HS_ON or LS_ON while armed was already 1.
- DT_MEAS is loaded with the gap count. The count is 0 for a direct HS_ON↔LS_ON swap with no both-low sample.
- DT_VALID pulses with the load.
- DT_ERR pulses if the value < MIN_DT.
- A same-side re-entry (HS_ON→OFF→HS_ON) is also measured.
- An entry from FAULT is not measured.

Shoot-through:
- On entry into FAULT, SHOOT is set and FAULT_CNT increments (saturating).
- Remaining in FAULT counts as one event only.

CLR:
- Clears SHOOT and FAULT_CNT and disarms.
- If CLR coincides with a FAULT entry, the set/increment wins: SHOOT=1, FAULT_CNT=1.
- CLR does not affect DT_MEAS.

RST:
- Asserted mid-operation, it returns to OFF immediately.
- Clears all outputs, the counters, the armed flag and the sample/sync flops.

## Timing
- Reset values:
  - DT_MEAS=0, DT_VALID=0, DT_ERR=0, SHOOT=0, FAULT_CNT=0.
  - FSM in OFF, gap counter 0, armed 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Latency, input edge to DT_VALID/SHOOT assertion:
  - 2 CLK edges without DTM_SYNC_EN.
  - 4 CLK edges with DTM_SYNC_EN.
- A gap of N input cycles between one gate falling and the other rising reports DT_MEAS=N.
- DT_VALID and DT_ERR are high for exactly one cycle per measurement.

## Configuration
DTM_SYNC_EN:
- Defined: HS and LS each pass through a two-flop synchronizer in front of the sample register, for gate signals from another clock domain or from pins. Latency becomes 4.
- Undefined: the inputs are assumed CLK-synchronous and go straight to the sample register. Latency is 2.
- Measured gap values are identical in both builds.

## Structure
- Shared package/include dtm_pkg holds:
  - the state encoding constants ST_OFF, ST_HS_ON, ST_LS_ON, ST_FAULT;
  - the default MIN_DT constant, shared with the dead-time generator so both use one dead-time value.
- One sub-module, dtm_sync2: a 1-bit two-flop synchronizer with async active-high reset. It is instantiated twice, only under DTM_SYNC_EN.

## Test plan
- HS high 20 cycles → both low 11 cycles → LS high: one DT_VALID pulse, DT_MEAS=11, DT_ERR=0.
- LS falls, both low 5 cycles, HS rises: DT_MEAS=5, DT_ERR=1. Direct swap with 0 both-low cycles: DT_MEAS=0, DT_ERR=1.
- First HS pulse after reset, after 30 low cycles: no DT_VALID (not armed). The following LS entry is measured normally.
- HS and LS both high for 3 cycles, twice: SHOOT=1, FAULT_CNT=2. CLR pulse → SHOOT=0, FAULT_CNT=0. CLR coinciding with a new overlap → SHOOT=1, FAULT_CNT=1.
- Both low for 300 cycles with CNT_W=8 before LS rises: DT_MEAS=255, DT_ERR=0.
- RST asserted mid-gap (cycle 6 of 11): all outputs 0 immediately. The next on-entry is not measured. Repeat the first scenario with DTM_SYNC_EN defined: same DT_MEAS, DT_VALID 2 cycles later.
